// File: rtl/key_run_ctrl_pkg.sv
// Shared types and defaults for the run/stop key front end.
// State encodings are fixed (IDLE=0, RUN=1, STOPPED=2) so external
// debug tooling can decode the exported state value.
package key_run_ctrl_pkg;

    localparam int KRC_DEBOUNCE_CYCLES = 500_000;     // 10 ms at 50 MHz
    localparam int KRC_HOLD_CYCLES     = 100_000_000; // 2 s at 50 MHz
    localparam int KRC_CNT_W           = 27;

    typedef enum logic [1:0] {
        KRC_IDLE = 2'd0,
        KRC_RUN  = 2'd1,
        KRC_STOP = 2'd2
    } krc_state_t;

    // A debounced press moves RUN to STOPPED and anything else to RUN.
    function automatic krc_state_t krc_toggle(krc_state_t s);
        return (s == KRC_RUN) ? KRC_STOP : KRC_RUN;
    endfunction

endpackage

// File: rtl/key_run_ctrl_if.sv
// Signal bundle between the run/stop key stage and its surroundings.
// key_n is the raw active-low button; every other signal is driven by the
// control stage. All outputs are levels or one-cycle strobes on clk; there
// is no valid/ready handshake: press_pulse and clear_pulse are
// fire-and-forget strobes that consumers must sample on the cycle they are high.
interface key_run_ctrl_if;
    import key_run_ctrl_pkg::*;

    logic       key_n;
    logic       key_clean;
    logic       press_pulse;
    logic       run;
    logic       stop;
    logic       clear_pulse;
    krc_state_t state;        // FSM state, exported for debug and checkers

    modport master (
        output key_n,
        input  key_clean, press_pulse, run, stop, clear_pulse, state
    );

    modport slave (
        input  key_n,
        output key_clean, press_pulse, run, stop, clear_pulse, state
    );
endinterface

// File: rtl/key_run_ctrl_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low key.
// key_clean_o follows the synchronised key only after it has differed from
// key_clean_o for DEBOUNCE_CYCLES consecutive clocks; any bounce back
// restarts the count. press_pulse_o strobes on the clock key_clean_o falls.
// Reusable for any of the board keys.
module key_run_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic key_clean_o,
    output logic press_pulse_o
);

    logic             sync1_q;
    logic             key_s_q;
    logic             key_clean_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise the asynchronous key; reset to the released level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            key_s_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; adopt the new level when the count completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_clean_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (key_s_q == key_clean_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                key_clean_q <= key_s_q;
                cnt_q       <= '0;
                press_q     <= ~key_s_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign key_clean_o   = key_clean_q;
    assign press_pulse_o = press_q;

endmodule

// File: rtl/key_run_ctrl.sv
// Run/stop control stage: debounced key drives an IDLE/RUN/STOPPED machine
// whose RUN level enables the downstream rng, sum_3 and counter stages.
// Optional feature macro: HOLD_CLEAR_EN -- a long press (HOLD_CYCLES clocks
// with the debounced key low outside IDLE) returns the machine to IDLE and
// strobes clear_pulse once per press. Without it clear_pulse is tied low.
module key_run_ctrl
    import key_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KRC_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = KRC_HOLD_CYCLES,
    parameter int CNT_W           = KRC_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    key_run_ctrl_if.slave  bus
);

    // Reject configurations whose counters cannot reach their terminal count.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(HOLD_CYCLES) > (longint'(1) << CNT_W)) begin : g_cfg_check
        $error("key_run_ctrl: CNT_W too small for DEBOUNCE_CYCLES/HOLD_CYCLES");
    end

    logic       key_clean;
    logic       press_pulse;
    logic       clear_fire;
    krc_state_t state_q;
    krc_state_t state_d;

    key_run_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .key_n_i       (bus.key_n),
        .key_clean_o   (key_clean),
        .press_pulse_o (press_pulse)
    );

`ifdef HOLD_CLEAR_EN
    logic [CNT_W-1:0] hold_cnt_q;
    logic             hold_done_q;

    // Fires once when the press has been held long enough outside IDLE.
    assign clear_fire = !key_clean && (state_q != KRC_IDLE) && !hold_done_q &&
                        (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Hold counter: runs while pressed outside IDLE, saturates after the clear, resets on release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
        end else if (key_clean) begin
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
        end else if ((state_q != KRC_IDLE) && !hold_done_q) begin
            if (clear_fire) begin
                hold_done_q <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end
`else
    assign clear_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= KRC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: long-press clear wins over a press; illegal encodings recover to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KRC_IDLE, KRC_RUN, KRC_STOP: begin
                if (clear_fire) begin
                    state_d = KRC_IDLE;
                end else if (press_pulse) begin
                    state_d = krc_toggle(state_q);
                end
            end
            default: state_d = KRC_IDLE;
        endcase
    end

    assign bus.key_clean   = key_clean;
    assign bus.press_pulse = press_pulse;
    assign bus.run         = (state_q == KRC_RUN);
    assign bus.stop        = (state_q == KRC_STOP);
    assign bus.clear_pulse = clear_fire;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_key_run_ctrl.sv
// Bench for key_run_ctrl with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=16.
// The reference model works on sample histories: key_n is delayed two clocks,
// and the clean level flips when the last DEBOUNCE_CYCLES delayed samples all
// disagree with it. Mode is tracked as idle/run/stopped with toggle-on-press.
module tb_key_run_ctrl;
    import key_run_ctrl_pkg::*;

    localparam int D = 4;
    localparam int H = 16;
`ifdef HOLD_CLEAR_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_run_ctrl_if bus ();

    key_run_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic sync_q[$];   // key_n delayed through the synchroniser
    logic win_q[$];    // most recent D synchronised samples
    logic m_clean = 1'b1;
    logic m_press = 1'b0;
    logic m_clear = 1'b0;
    int   m_mode  = 0;    // 0 idle, 1 running, 2 stopped
    int   m_hold  = 0;    // edges held low outside idle
    bit   m_done  = 1'b0; // clear already issued for this press

    function automatic logic [4:0] exp_vec();
        return {m_clean, m_press, (m_mode == 1), (m_mode == 2), m_clear};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.key_clean, bus.press_pulse, bus.run, bus.stop, bus.clear_pulse};
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input logic kn, input logic rs);
        logic pre_press;
        logic pre_clean;
        logic pre_clear;
        int   pre_mode;
        logic s;
        bit   flip;
        bus.key_n = kn;
        rst       = rs;
        @(posedge clk);
        pre_press = m_press;
        pre_clean = m_clean;
        pre_clear = m_clear;
        pre_mode  = m_mode;
        if (!rs) begin
            sync_q  = '{1'b1, 1'b1};
            win_q.delete();
            m_clean = 1'b1;
            m_press = 1'b0;
            m_mode  = 0;
            m_hold  = 0;
            m_done  = 1'b0;
        end else begin
            s = sync_q.pop_front();
            sync_q.push_back(kn);
            win_q.push_back(s);
            if (win_q.size() > D) void'(win_q.pop_front());
            flip = (win_q.size() == D);
            foreach (win_q[i]) if (win_q[i] == m_clean) flip = 1'b0;
            m_press = 1'b0;
            if (flip) begin
                m_clean = ~m_clean;
                m_press = ~m_clean;
            end
            if (pre_clear) m_mode = 0;
            else if (pre_press) m_mode = (m_mode == 1) ? 2 : 1;
            if (HOLD_ON) begin
                if (pre_clean) begin
                    m_hold = 0;
                    m_done = 1'b0;
                end else if (pre_mode != 0 && !m_done) begin
                    m_hold++;
                    if (m_hold == H) m_done = 1'b1;
                end
            end
        end
        m_clear = HOLD_ON && !m_clean && (m_mode != 0) && !m_done && (m_hold == H - 1);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        n_tests++;
        if (dut_vec() !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", dut_vec(), 5'b10000);
        end
        n_tests++;
        if (bus.state !== KRC_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", bus.state, KRC_IDLE);
        end
    endtask

    task automatic test_clean_press();
        int presses = 0;
        int press_at = -1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b1);
            if (bus.press_pulse === 1'b1) begin
                presses++;
                if (press_at < 0) press_at = k;
            end
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL press_cycle%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (presses !== 1 || press_at !== 6) begin
            n_fail++;
            $display("FAIL press_timing: got %0d pulses at edge %0d expected 1 at edge 6", presses, press_at);
        end
        presses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1, 1'b1);
            if (bus.press_pulse === 1'b1) presses++;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL release_cycle%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (presses !== 0 || bus.run !== 1'b1) begin
            n_fail++;
            $display("FAIL release_no_pulse: got pulses=%0d run=%b expected pulses=0 run=1", presses, bus.run);
        end
    endtask

    task automatic test_bounce();
        int   presses = 0;
        logic run0 = bus.run;
        logic stop0 = bus.stop;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick((c == 3) ? 1'b1 : 1'b0, 1'b1);
                if (bus.press_pulse === 1'b1) presses++;
                n_tests++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL bounce_r%0d_c%0d: got %b expected %b", r, c, dut_vec(), exp_vec());
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        n_tests++;
        if (presses !== 0 || bus.run !== run0 || bus.stop !== stop0) begin
            n_fail++;
            $display("FAIL bounce_hold: got pulses=%0d run=%b stop=%b expected 0 %b %b",
                     presses, bus.run, bus.stop, run0, stop0);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] want [3] = '{2'b10, 2'b01, 2'b10};
        tick(1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
            n_tests++;
            if ({bus.run, bus.stop} !== want[p] || {bus.run, bus.stop} !== exp_vec()[2:1]) begin
                n_fail++;
                $display("FAIL sequence_press%0d: got run,stop=%b expected %b", p, {bus.run, bus.stop}, want[p]);
            end
            for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int press_at = -1;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        n_tests++;
        if (bus.press_pulse !== 1'b0 || bus.key_clean !== 1'b1 || bus.state !== KRC_IDLE) begin
            n_fail++;
            $display("FAIL mid_debounce_reset: got press=%b clean=%b state=%0d expected 0 1 0",
                     bus.press_pulse, bus.key_clean, bus.state);
        end
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 1'b1);
            if (bus.press_pulse === 1'b1 && press_at < 0) press_at = k;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL redebounce_cycle%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (press_at !== 6) begin
            n_fail++;
            $display("FAIL redebounce_latency: got edge %0d expected 6", press_at);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    endtask

    task automatic test_hold();
        int clears = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick((k <= 30) ? 1'b0 : 1'b1, 1'b1);
            if (bus.clear_pulse === 1'b1) clears++;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (clears !== (HOLD_ON ? 1 : 0) || bus.stop !== !HOLD_ON || bus.run !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_result: got clears=%0d run=%b stop=%b expected %0d 0 %b",
                     clears, bus.run, bus.stop, HOLD_ON ? 1 : 0, !HOLD_ON);
        end
    endtask

    task automatic test_random();
        logic kn = 1'b1;
        int   seg = 0;
        tick(1'b1, 1'b0);
        for (int k = 0; k < 1500; k++) begin
            if (seg == 0) begin
                kn  = 1'($urandom_range(0, 1));
                seg = $urandom_range(1, (k % 3 == 0) ? 30 : 8);
            end
            seg--;
            tick(kn, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.key_n = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_reset_mid_debounce();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
